// File: rtl/act_fmt_pkg.sv
// Shared format codes, FP16/INT16 constants and the packed AXIS beat record
// used by the activation output round-and-pack stage.
package act_fmt_pkg;

   typedef enum logic [1:0] {
      ACT_CAL_FMT_INT16 = 2'b00,
      ACT_CAL_FMT_INT32 = 2'b01,
      ACT_CAL_FMT_FP32  = 2'b10,
      ACT_CAL_FMT_NONE  = 2'b11
   } act_cal_fmt_e;

   localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
   localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
   localparam logic [15:0] FP16_QNAN     = 16'h7E00;
   localparam int          FP16_EXP_BIAS = 15;
   localparam int          FP32_EXP_BIAS = 127;

   localparam int INT16_MAX = 32767;
   localparam int INT16_MIN = -32768;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } axis_beat_t;

   function automatic logic [15:0] sat_int16(input logic [31:0] v);
      logic [15:0] r;
      if ($signed(v) > INT16_MAX) begin
         r = 16'(INT16_MAX);
      end else if ($signed(v) < INT16_MIN) begin
         r = 16'(INT16_MIN);
      end else begin
         r = v[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/fp32_to_fp16_rne.sv
// Combinational FP32 -> FP16 narrowing with round-to-nearest-even.
// Results below the smallest FP16 normal flush to signed zero.
module fp32_to_fp16_rne
   import act_fmt_pkg::*;
(
   input  logic [31:0] fp32,
   output logic [15:0] fp16
);

   localparam logic [7:0] EXP_MIN = 8'(FP32_EXP_BIAS - FP16_EXP_BIAS);
   localparam logic [7:0] EXP_MAX = 8'(FP32_EXP_BIAS + FP16_EXP_BIAS);

   logic        sign;
   logic [7:0]  exp32;
   logic [22:0] man32;
   logic        round_up;
   logic [4:0]  exp16;
   logic [14:0] mag;

   assign sign  = fp32[31];
   assign exp32 = fp32[30:23];
   assign man32 = fp32[22:0];

   // guard bit set and either sticky bits or an odd kept LSB
   assign round_up = man32[12] & ((|man32[11:0]) | man32[13]);
   assign exp16    = 5'(exp32 - EXP_MIN);
   assign mag      = {exp16, man32[22:13]} + {14'd0, round_up};

   always_comb begin
      fp16 = {sign, 15'd0};
      if (exp32 == 8'hFF) begin
         fp16 = (man32 != '0) ? FP16_QNAN : (sign ? FP16_NEG_INF : FP16_POS_INF);
      end else if (exp32 > EXP_MAX) begin
         fp16 = sign ? FP16_NEG_INF : FP16_POS_INF;
      end else if (exp32 >= EXP_MIN) begin
         // exponent field 0 after rounding means still below 2^-14
         if (mag[14:10] == 5'h1F) begin
            fp16 = sign ? FP16_NEG_INF : FP16_POS_INF;
         end else if (mag[14:10] != 5'd0) begin
            fp16 = {sign, mag};
         end
      end
   end

endmodule

// File: rtl/act_out_round_pack.sv
// Narrows activation results to 16 bits, packs four per 64-bit AXIS beat and
// buffers beats in a FWFT FIFO, raising in_stall ahead of a possible overrun.
module act_out_round_pack
   import act_fmt_pkg::*;
#(
   parameter int INFO_ALONG_WIDTH = 2,
   parameter int FIFO_DEPTH       = 16,
   parameter int STALL_SLACK      = 4,
   parameter int SIM_DELAY        = 1
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [1:0]                  act_calfmt,
   input  logic [31:0]                 in_res,
   input  logic [INFO_ALONG_WIDTH-1:0] in_info_along,
   input  logic                        in_vld,
   output logic                        in_stall,
   output logic [63:0]                 m_axis_data,
   output logic [7:0]                  m_axis_keep,
   output logic                        m_axis_last,
   output logic                        m_axis_valid,
   input  logic                        m_axis_ready,
   output logic                        err_ovf
);

   localparam int          AW           = $clog2(FIFO_DEPTH);
   localparam int          STALL_THRESH = (STALL_SLACK + 3) / 4 + 2;
   localparam logic [AW:0] DEPTH_W      = FIFO_DEPTH[AW:0];
   localparam logic [AW:0] THRESH_W     = STALL_THRESH[AW:0];
   localparam logic [AW:0] PTR_ONE      = {{AW{1'b0}}, 1'b1};

   // input capture
   logic        in_vld_reg;
   logic [31:0] in_res_reg;
   logic        in_last_reg;

   // stage C
   logic [15:0] fp16_res;
   logic [15:0] conv_next;
   logic        c_vld_reg;
   logic [15:0] c_data_reg;
   logic        c_last_reg;

   // stage P
   logic [1:0]  lane_reg;
   logic [63:0] beat_reg;
   logic [63:0] merged;
   logic [7:0]  lane_keep;
   logic        push;
   axis_beat_t  push_beat;

   // FIFO
   axis_beat_t  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic [AW:0] count;
   logic [AW:0] free;
   logic        empty;
   logic        full;
   logic        pop;
   logic        wr_en;
   axis_beat_t  head;
   logic        stall_reg;
   logic        ovf_reg;

   logic unused_ok;
   assign unused_ok = ^{in_info_along, (SIM_DELAY != 0)};

   always_ff @(posedge aclk) begin
      if (areset) begin
         in_vld_reg  <= 1'b0;
         in_res_reg  <= 32'd0;
         in_last_reg <= 1'b0;
      end else begin
         in_vld_reg  <= in_vld;
         in_res_reg  <= in_res;
         in_last_reg <= in_info_along[0];
      end
   end

   fp32_to_fp16_rne u_fp32_to_fp16 (
      .fp32 (in_res_reg),
      .fp16 (fp16_res)
   );

   always_comb begin
      conv_next = in_res_reg[15:0];
      case (act_cal_fmt_e'(act_calfmt))
         ACT_CAL_FMT_INT16, ACT_CAL_FMT_INT32: conv_next = sat_int16(in_res_reg);
         ACT_CAL_FMT_FP32:                     conv_next = fp16_res;
         default:                              conv_next = in_res_reg[15:0];
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         c_vld_reg  <= 1'b0;
         c_data_reg <= 16'd0;
         c_last_reg <= 1'b0;
      end else begin
         c_vld_reg  <= in_vld_reg;
         c_data_reg <= conv_next;
         c_last_reg <= in_last_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[16*gi +: 16]  = (lane_reg == 2'(gi)) ? c_data_reg : beat_reg[16*gi +: 16];
         assign lane_keep[2*gi +: 2] = (2'(gi) <= lane_reg) ? 2'b11 : 2'b00;
      end
   endgenerate

   assign push           = c_vld_reg && ((lane_reg == 2'd3) || c_last_reg);
   assign push_beat.data = merged;
   assign push_beat.keep = lane_keep;
   assign push_beat.last = c_last_reg;

   // beat_reg is cleared on every push so lanes not yet filled stay zero
   always_ff @(posedge aclk) begin
      if (areset) begin
         lane_reg <= 2'd0;
         beat_reg <= 64'd0;
      end else if (c_vld_reg) begin
         if (push) begin
            lane_reg <= 2'd0;
            beat_reg <= 64'd0;
         end else begin
            lane_reg <= lane_reg + 2'd1;
            beat_reg <= merged;
         end
      end
   end

   assign count = wr_ptr_reg - rd_ptr_reg;
   assign free  = DEPTH_W - count;
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (count == DEPTH_W);
   assign pop   = !empty && m_axis_ready;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_beat;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         stall_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         stall_reg <= (free <= THRESH_W);
         if (push && full && !pop) begin
            ovf_reg <= 1'b1;
         end
      end
   end

   assign head         = mem[rd_ptr_reg[AW-1:0]];
   assign m_axis_valid = !empty;
   assign m_axis_data  = empty ? 64'd0 : head.data;
   assign m_axis_keep  = empty ? 8'd0 : head.keep;
   assign m_axis_last  = empty ? 1'b0 : head.last;
   assign in_stall     = stall_reg;
   assign err_ovf      = ovf_reg;

endmodule

// File: tb/tb_act_out_round_pack.sv
// Directed vector table plus stall/overflow, random-backpressure and
// mid-stream reset sequences for act_out_round_pack.
module tb_act_out_round_pack;

   localparam int DEPTH = 16;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   typedef struct {
      logic [1:0]  fmt;
      logic [31:0] res;
      logic        last;
      logic        chk;
      beat_t       exp;
   } vec_t;

   logic        aclk;
   logic        areset;
   logic [1:0]  act_calfmt;
   logic [31:0] in_res;
   logic [1:0]  in_info_along;
   logic        in_vld;
   logic        in_stall;
   logic [63:0] m_axis_data;
   logic [7:0]  m_axis_keep;
   logic        m_axis_last;
   logic        m_axis_valid;
   logic        m_axis_ready;
   logic        err_ovf;

   int    total = 0;
   int    bad   = 0;
   int    nbeat = 0;
   int    mon_mode = 0;   // 0 ready=1 check, 1 random check, 2 ready=0, 3 ready=1 no check
   beat_t exp_q[$];

   act_out_round_pack #(
      .INFO_ALONG_WIDTH (2),
      .FIFO_DEPTH       (DEPTH),
      .STALL_SLACK      (4),
      .SIM_DELAY        (1)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .act_calfmt    (act_calfmt),
      .in_res        (in_res),
      .in_info_along (in_info_along),
      .in_vld        (in_vld),
      .in_stall      (in_stall),
      .m_axis_data   (m_axis_data),
      .m_axis_keep   (m_axis_keep),
      .m_axis_last   (m_axis_last),
      .m_axis_valid  (m_axis_valid),
      .m_axis_ready  (m_axis_ready),
      .err_ovf       (err_ovf)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      beat_t e;
      case (mon_mode)
         1:       m_axis_ready = 1'($urandom_range(0, 1));
         2:       m_axis_ready = 1'b0;
         default: m_axis_ready = 1'b1;
      endcase
      if (m_axis_valid && m_axis_ready && (mon_mode == 0 || mon_mode == 1)) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat%0d unexpected: data=%h keep=%h last=%b", nbeat,
                     m_axis_data, m_axis_keep, m_axis_last);
         end else begin
            e = exp_q.pop_front();
            if (m_axis_data !== e.data || m_axis_keep !== e.keep || m_axis_last !== e.last) begin
               bad++;
               $display("FAIL beat%0d: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                        nbeat, m_axis_data, m_axis_keep, m_axis_last, e.data, e.keep, e.last);
            end else begin
               $display("beat%0d ok: data=%h keep=%h last=%b", nbeat, m_axis_data,
                        m_axis_keep, m_axis_last);
            end
         end
         nbeat++;
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end else begin
         $display("%s ok: %h", name, act);
      end
   endtask

   task automatic wait_empty(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_axis_valid) && n < limit) begin
         step();
         n++;
      end
      total++;
      if (exp_q.size() != 0 || m_axis_valid) begin
         bad++;
         $display("FAIL drain_timeout: %0d beats still expected, valid=%b", exp_q.size(), m_axis_valid);
      end
   endtask

   task automatic set_fmt(input logic [1:0] f);
      in_vld = 1'b0;
      repeat (4) step();
      act_calfmt = f;
   endtask

   task automatic drive(input logic [31:0] r, input logic l);
      in_vld        = 1'b1;
      in_res        = r;
      in_info_along = {1'b0, l};
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(m_axis_valid), 64'd0);
      chk({tag, "_data"},  m_axis_data, 64'd0);
      chk({tag, "_keep"},  64'(m_axis_keep), 64'd0);
      chk({tag, "_last"},  64'(m_axis_last), 64'd0);
      chk({tag, "_stall"}, 64'(in_stall), 64'd0);
      chk({tag, "_ovf"},   64'(err_ovf), 64'd0);
   endtask

   function automatic logic [15:0] sat_model(input logic [31:0] v);
      int s;
      s = $signed(v);
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return v[15:0];
   endfunction

   vec_t vecs[20];

   initial begin
      logic [63:0] acc;
      int          ln;
      int          n;
      int          cyc;
      int          stall_at;
      logic [31:0] r;
      logic        l;
      beat_t       b;

      vecs[0]  = '{2'b10, 32'h3F800000, 1'b0, 1'b0, '0};
      vecs[1]  = '{2'b10, 32'h3F801000, 1'b0, 1'b0, '0};
      vecs[2]  = '{2'b10, 32'h3F803000, 1'b0, 1'b0, '0};
      vecs[3]  = '{2'b10, 32'h477FF000, 1'b1, 1'b1, '{64'h7C00_3C02_3C00_3C00, 8'hFF, 1'b1}};
      vecs[4]  = '{2'b10, 32'h7FC00001, 1'b0, 1'b0, '0};
      vecs[5]  = '{2'b10, 32'h38000000, 1'b0, 1'b0, '0};
      vecs[6]  = '{2'b10, 32'hFF800000, 1'b0, 1'b0, '0};
      vecs[7]  = '{2'b10, 32'h80000001, 1'b0, 1'b1, '{64'h8000_FC00_0000_7E00, 8'hFF, 1'b0}};
      vecs[8]  = '{2'b10, 32'h3FC00000, 1'b0, 1'b0, '0};
      vecs[9]  = '{2'b10, 32'hC0000000, 1'b0, 1'b0, '0};
      vecs[10] = '{2'b10, 32'h477FE000, 1'b0, 1'b0, '0};
      vecs[11] = '{2'b10, 32'h38800000, 1'b1, 1'b1, '{64'h0400_7BFF_C000_3E00, 8'hFF, 1'b1}};
      vecs[12] = '{2'b01, 32'h00009C40, 1'b0, 1'b0, '0};
      vecs[13] = '{2'b01, 32'hFFFF63C0, 1'b1, 1'b1, '{64'h0000_0000_8000_7FFF, 8'h0F, 1'b1}};
      vecs[14] = '{2'b01, 32'h000004D2, 1'b0, 1'b0, '0};
      vecs[15] = '{2'b01, 32'hFFFFFFFB, 1'b1, 1'b1, '{64'h0000_0000_FFFB_04D2, 8'h0F, 1'b1}};
      vecs[16] = '{2'b00, 32'h00001234, 1'b0, 1'b0, '0};
      vecs[17] = '{2'b00, 32'hFFFF8000, 1'b0, 1'b0, '0};
      vecs[18] = '{2'b00, 32'h00008000, 1'b1, 1'b1, '{64'h0000_7FFF_8000_1234, 8'h3F, 1'b1}};
      vecs[19] = '{2'b11, 32'hABCD5678, 1'b1, 1'b1, '{64'h0000_0000_0000_5678, 8'h03, 1'b1}};

      areset        = 1'b1;
      act_calfmt    = 2'b10;
      in_res        = 32'd0;
      in_info_along = 2'b00;
      in_vld        = 1'b0;
      mon_mode      = 0;
      repeat (3) step();
      check_reset_outputs("reset");
      areset = 1'b0;
      step();

      // directed vector table
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].fmt != act_calfmt) set_fmt(vecs[i].fmt);
         if (vecs[i].chk) exp_q.push_back(vecs[i].exp);
         drive(vecs[i].res, vecs[i].last);
      end
      in_vld = 1'b0;
      wait_empty(60);

      // random backpressure, INT32 saturation scoreboard
      set_fmt(2'b01);
      mon_mode = 1;
      acc = 64'd0;
      ln  = 0;
      n   = 0;
      cyc = 0;
      while (n < 256 && cyc < 5000) begin
         cyc++;
         if (in_stall) begin
            in_vld = 1'b0;
            step();
         end else begin
            case ($urandom_range(0, 3))
               0:       r = 32'($urandom_range(0, 65535)) - 32'd32768;
               1: begin
                  case ($urandom_range(0, 3))
                     0:       r = 32'd32767;
                     1:       r = 32'd32768;
                     2:       r = 32'hFFFF8000;
                     default: r = 32'hFFFF7FFF;
                  endcase
               end
               default: r = $urandom;
            endcase
            l = (n == 255) || ($urandom_range(0, 7) == 0);
            acc[16*ln +: 16] = sat_model(r);
            if (ln == 3 || l) begin
               b.data = acc;
               b.keep = 8'hFF >> (2 * (3 - ln));
               b.last = l;
               exp_q.push_back(b);
               acc = 64'd0;
               ln  = 0;
            end else begin
               ln++;
            end
            drive(r, l);
            n++;
         end
      end
      in_vld = 1'b0;
      chk("rand_count", 64'(n), 64'd256);
      wait_empty(600);
      mon_mode = 0;
      chk("rand_ovf", 64'(err_ovf), 64'd0);

      // stall threshold with ready held low
      set_fmt(2'b10);
      mon_mode = 2;
      step();
      stall_at = -1;
      for (int c = 0; c < 200 && stall_at < 0; c++) begin
         drive(32'h3F800000, 1'b0);
         if (c >= 2) begin
            int free_m;
            free_m = DEPTH - (c - 2) / 4;
            if (free_m >= 5) chk($sformatf("stall_lo_c%0d", c), 64'(in_stall), 64'd0);
            else if (free_m <= 3) chk($sformatf("stall_hi_c%0d", c), 64'(in_stall), 64'd1);
         end
         if (in_stall) stall_at = c;
      end
      total++;
      if (stall_at < 0) begin
         bad++;
         $display("FAIL stall_timeout: in_stall never asserted");
      end
      repeat (4) drive(32'h3F800000, 1'b0);
      in_vld = 1'b0;
      repeat (10) step();
      chk("slack_ovf", 64'(err_ovf), 64'd0);
      chk("slack_stall_held", 64'(in_stall), 64'd1);

      // ignore in_stall: overflow must be flagged and stay sticky
      repeat (40) drive(32'h3F800000, 1'b0);
      in_vld = 1'b0;
      repeat (4) step();
      chk("ovf_set", 64'(err_ovf), 64'd1);
      mon_mode = 3;
      repeat (40) step();
      chk("ovf_sticky", 64'(err_ovf), 64'd1);
      chk("drained_stall", 64'(in_stall), 64'd0);
      chk("drained_valid", 64'(m_axis_valid), 64'd0);

      // reset mid-beat, then a clean beat with measured latency
      drive(32'h3F800000, 1'b0);
      drive(32'h3F800000, 1'b0);
      in_vld = 1'b0;
      areset = 1'b1;
      step();
      areset = 1'b0;
      check_reset_outputs("midreset");
      mon_mode = 0;
      exp_q.push_back('{64'h3400_BC00_4200_4000, 8'hFF, 1'b1});
      drive(32'h40000000, 1'b0);
      drive(32'h40400000, 1'b0);
      drive(32'hBF800000, 1'b0);
      drive(32'h3E800000, 1'b1);
      in_vld = 1'b0;
      step();
      chk("lat_n1_valid", 64'(m_axis_valid), 64'd0);
      step();
      chk("lat_n2_valid", 64'(m_axis_valid), 64'd1);
      wait_empty(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
